// File: rtl/dexie_df_retire_buffer_pkg.sv
// Shared DExIE dataflow definitions: the retirement record layout
// (taiga_types slice) and the buffer sizing defaults (taiga_config slice).
package dexie_df_retire_buffer_pkg;

   // Default buffer depth; must be a power of two, at least 4.
   localparam int DEXIE_DF_DEPTH = 8;

   // Stall threshold leaves two entries of slack for events already in flight.
   function automatic int dexie_df_almost_full(input int depth);
      return depth - 2;
   endfunction

   // One retirement event as handed to the external checker.
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd_addr;
      logic [31:0] rd_val;
      logic [7:0]  seq;
   } dexie_df_record_t;

endpackage

// File: rtl/dexie_df_fifo_ram.sv
// Record storage for the retire buffer: synchronous write, asynchronous
// read, so it maps onto distributed RAM. Contents are not reset.
module dexie_df_fifo_ram
   import dexie_df_retire_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  dexie_df_record_t wr_data,
   input  logic [AW-1:0]    rd_addr,
   output dexie_df_record_t rd_data
);

   dexie_df_record_t mem [DEPTH];

   // Write the incoming record at the tail slot.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dexie_df_retire_buffer.sv
// Retirement event buffer between write-back and the DExIE checker.
// Stream handshake: a record transfers on a rising clk edge where
// df_out_valid and df_out_ready are both high; the head fields hold while
// valid is high and ready is low, and read as zero while the buffer is empty.
module dexie_df_retire_buffer
   import dexie_df_retire_buffer_pkg::*;
#(
   parameter int DEPTH       = DEXIE_DF_DEPTH,
   parameter int ALMOST_FULL = dexie_df_almost_full(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dexie_df_reg_pc,
   input  logic [4:0]  dexie_df_reg_rd_addr,
   input  logic [31:0] dexie_df_reg_rd_val,
   output logic        df_out_valid,
   input  logic        df_out_ready,
   output logic [31:0] df_out_pc,
   output logic [4:0]  df_out_rd_addr,
   output logic [31:0] df_out_rd_val,
   output logic [7:0]  df_out_seq,
   output logic        df_stall,
   output logic        df_overflow,
   input  logic        df_overflow_clear,
   output logic [15:0] df_drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;
   logic [CW-1:0]    count_q;
   logic [7:0]       seq_q;
   logic             overflow_q;
   logic [15:0]      drop_cnt_q;

   logic             push_req;
   logic             pop;
   logic             full;
   logic             push_accept;
   logic             drop;
   dexie_df_record_t wr_rec;
   dexie_df_record_t head_rec;

   assign push_req    = (dexie_df_reg_rd_addr != 5'd0);
   assign full        = (count_q == CW'(DEPTH));
   assign pop         = df_out_valid && df_out_ready;
   // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
   assign push_accept = push_req && (!full || pop);
   assign drop        = push_req && full && !pop;

   assign wr_rec.pc      = dexie_df_reg_pc;
   assign wr_rec.rd_addr = dexie_df_reg_rd_addr;
   assign wr_rec.rd_val  = dexie_df_reg_rd_val;
   assign wr_rec.seq     = seq_q;

   dexie_df_fifo_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push_accept),
      .wr_addr (tail_q),
      .wr_data (wr_rec),
      .rd_addr (head_q),
      .rd_data (head_rec)
   );

   // Pointers, occupancy and sequence tag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         seq_q   <= '0;
      end else begin
         if (push_accept) begin
            tail_q <= tail_q + AW'(1);
         end
         if (pop) begin
            head_q <= head_q + AW'(1);
         end
         case ({push_accept, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         // Every attempt consumes a tag so the checker can see drops as gaps.
         if (push_req) begin
            seq_q <= seq_q + 8'd1;
         end
      end
   end

   // Sticky overflow flag and saturating drop counter; clear wins over a drop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (df_overflow_clear) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign df_out_valid   = (count_q != '0);
   assign df_out_pc      = df_out_valid ? head_rec.pc      : 32'd0;
   assign df_out_rd_addr = df_out_valid ? head_rec.rd_addr : 5'd0;
   assign df_out_rd_val  = df_out_valid ? head_rec.rd_val  : 32'd0;
   assign df_out_seq     = df_out_valid ? head_rec.seq     : 8'd0;
   assign df_stall       = (count_q >= CW'(ALMOST_FULL));
   assign df_overflow    = overflow_q;
   assign df_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_dexie_df_retire_buffer.sv
// Directed bench for the retire buffer: expected records queue up as events
// are issued; a negedge monitor compares each accepted head record.
module tb_dexie_df_retire_buffer;

   logic        clk;
   logic        rst;
   logic [31:0] dexie_df_reg_pc;
   logic [4:0]  dexie_df_reg_rd_addr;
   logic [31:0] dexie_df_reg_rd_val;
   logic        df_out_valid;
   logic        df_out_ready;
   logic [31:0] df_out_pc;
   logic [4:0]  df_out_rd_addr;
   logic [31:0] df_out_rd_val;
   logic [7:0]  df_out_seq;
   logic        df_stall;
   logic        df_overflow;
   logic        df_overflow_clear;
   logic [15:0] df_drop_count;

   int checks = 0;
   int errors = 0;
   logic [76:0] exp_q[$];

   dexie_df_retire_buffer dut (
      .clk                  (clk),
      .rst                  (rst),
      .dexie_df_reg_pc      (dexie_df_reg_pc),
      .dexie_df_reg_rd_addr (dexie_df_reg_rd_addr),
      .dexie_df_reg_rd_val  (dexie_df_reg_rd_val),
      .df_out_valid         (df_out_valid),
      .df_out_ready         (df_out_ready),
      .df_out_pc            (df_out_pc),
      .df_out_rd_addr       (df_out_rd_addr),
      .df_out_rd_val        (df_out_rd_val),
      .df_out_seq           (df_out_seq),
      .df_stall             (df_stall),
      .df_overflow          (df_overflow),
      .df_overflow_clear    (df_overflow_clear),
      .df_drop_count        (df_drop_count)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver: present one event for one cycle; queue it if it should be kept.
   task automatic push_ev(input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] val, input logic [7:0] exp_seq,
                          input bit accept);
      dexie_df_reg_pc      = pc;
      dexie_df_reg_rd_addr = rd;
      dexie_df_reg_rd_val  = val;
      if (accept) exp_q.push_back({pc, rd, val, exp_seq});
      tick();
      dexie_df_reg_rd_addr = 5'd0;
   endtask

   task automatic drain();
      bit done = 0;
      df_out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0 && !df_out_valid) begin
            done = 1;
            break;
         end
         tick();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: got %0d queued expected 0", exp_q.size());
      end
   endtask

   // Scoreboard monitor: a transfer is committed at the next rising edge.
   always @(negedge clk) begin
      if (rst && df_out_valid && df_out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record: got seq %0d pc 0x%0h expected none", df_out_seq, df_out_pc);
         end else begin
            logic [76:0] e;
            logic [76:0] a;
            e = exp_q.pop_front();
            a = {df_out_pc, df_out_rd_addr, df_out_rd_val, df_out_seq};
            if (a !== e) begin
               errors++;
               $display("FAIL record: got 0x%0h expected 0x%0h", a, e);
            end
         end
      end
   end

   initial begin
      rst                  = 1'b0;
      dexie_df_reg_pc      = 32'd0;
      dexie_df_reg_rd_addr = 5'd0;
      dexie_df_reg_rd_val  = 32'd0;
      df_out_ready         = 1'b0;
      df_overflow_clear    = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_valid",    32'(df_out_valid),  32'd0);
      chk("rst_stall",    32'(df_stall),      32'd0);
      chk("rst_overflow", 32'(df_overflow),   32'd0);
      chk("rst_drop",     32'(df_drop_count), 32'd0);
      chk("rst_pc",       df_out_pc,          32'd0);
      chk("rst_seq",      32'(df_out_seq),    32'd0);
      rst = 1'b1;
      tick();

      // Three events streamed straight through, one cycle latency each
      df_out_ready = 1'b1;
      chk("t1_valid_before", 32'(df_out_valid), 32'd0);
      push_ev(32'h100, 5'd1, 32'hA1, 8'd0, 1);
      chk("t1_valid_after", 32'(df_out_valid), 32'd1);
      chk("t1_seq_after",   32'(df_out_seq),   32'd0);
      push_ev(32'h104, 5'd2, 32'hA2, 8'd1, 1);
      push_ev(32'h108, 5'd3, 32'hA3, 8'd2, 1);
      chk("t1_stall", 32'(df_stall), 32'd0);
      drain();

      // Six events with back-pressure: stall rises after the sixth
      df_out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push_ev(32'h200 + 32'(4 * i), 5'(4 + i), 32'hB0 + 32'(i), 8'(3 + i), 1);
         chk("t2_head_pc",  df_out_pc,          32'h200);
         chk("t2_head_seq", 32'(df_out_seq),    32'd3);
         chk("t2_stall",    32'(df_stall),      (i == 5) ? 32'd1 : 32'd0);
      end
      chk("t2_overflow", 32'(df_overflow), 32'd0);
      drain();
      chk("t2_stall_after_drain", 32'(df_stall), 32'd0);

      // Fresh reset, then ten events into an eight-entry buffer
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      df_out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         push_ev(32'h300 + 32'(4 * i), 5'd7, 32'hC0 + 32'(i), 8'(i), i < 8);
      end
      chk("t3_drop",     32'(df_drop_count), 32'd2);
      chk("t3_overflow", 32'(df_overflow),   32'd1);
      chk("t3_stall",    32'(df_stall),      32'd1);
      chk("t3_head_seq", 32'(df_out_seq),    32'd0);
      drain();
      push_ev(32'h400, 5'd8, 32'hD0, 8'd10, 1);
      drain();

      // Full buffer with simultaneous push and pop for 20 cycles
      df_out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_ev(32'h500 + 32'(4 * i), 5'd9, 32'hE0 + 32'(i), 8'(11 + i), 1);
      end
      df_out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push_ev(32'h600 + 32'(4 * i), 5'd10, 32'hF0 + 32'(i), 8'(19 + i), 1);
         chk("t4_stall", 32'(df_stall), 32'd1);
      end
      chk("t4_drop", 32'(df_drop_count), 32'd2);
      drain();

      // rd_addr == 0 is not an event, even with live pc/val
      dexie_df_reg_pc     = 32'hDEAD_BEEF;
      dexie_df_reg_rd_val = 32'h1234_5678;
      repeat (3) tick();
      chk("t5_valid", 32'(df_out_valid), 32'd0);
      push_ev(32'h700, 5'd11, 32'h77, 8'd39, 1);
      drain();

      // Overflow clear wins over a same-cycle drop
      df_out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push_ev(32'h800 + 32'(4 * i), 5'd12, 32'h80 + 32'(i), 8'(40 + i), 1);
      end
      chk("t6_overflow_pre", 32'(df_overflow),   32'd1);
      chk("t6_drop_pre",     32'(df_drop_count), 32'd2);
      df_overflow_clear = 1'b1;
      push_ev(32'h900, 5'd13, 32'h90, 8'd48, 0);
      df_overflow_clear = 1'b0;
      chk("t6_overflow_clr", 32'(df_overflow),   32'd0);
      chk("t6_drop_clr",     32'(df_drop_count), 32'd0);
      push_ev(32'h904, 5'd13, 32'h91, 8'd49, 0);
      chk("t6_overflow_set", 32'(df_overflow),   32'd1);
      chk("t6_drop_one",     32'(df_drop_count), 32'd1);
      df_overflow_clear = 1'b1;
      tick();
      df_overflow_clear = 1'b0;
      chk("t6_drop_clr2", 32'(df_drop_count), 32'd0);
      drain();

      // Mid-stream reset discards buffered records immediately
      df_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_ev(32'hA00 + 32'(4 * i), 5'd14, 32'hAA, 8'(50 + i), 0);
      end
      chk("t7_valid_pre", 32'(df_out_valid), 32'd1);
      rst = 1'b0;
      #2;
      chk("t7_valid_rst", 32'(df_out_valid), 32'd0);
      chk("t7_pc_rst",    df_out_pc,         32'd0);
      chk("t7_seq_rst",   32'(df_out_seq),   32'd0);
      tick();
      rst = 1'b1;
      tick();
      df_out_ready = 1'b1;
      push_ev(32'hB00, 5'd15, 32'hBB, 8'd0, 1);
      drain();

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
